// File: rtl/bus_resp_pkg.sv
// bus_resp_pkg: shared types and helpers for the 65C02 bus responder.
//   state_t     - responder FSM states (IDLE, EXT, DONE)
//   CNT_W       - width of the external wait-state counter
//   db_sel_t    - source of the DB read bus (hold register or RAM output)
//   is_internal - decode of the on-chip RAM window
package bus_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  typedef enum logic {
    DB_SEL_HOLD = 1'b0,
    DB_SEL_RAM  = 1'b1
  } db_sel_t;

  // True when addr falls inside the internal window 0 .. 2^aw-1.
  // Bits at and above aw are decode only; there is no wrap.
  function automatic logic is_internal(input logic [15:0] addr, input int unsigned aw);
    return (addr >> aw) == 16'h0000;
  endfunction

endpackage

// File: rtl/bus_resp_ram.sv
// bus_resp_ram: single-port synchronous RAM, 2^AW x 8, registered read,
// write-first (a write also drives the written byte onto the read port).
// Contents are not reset.
//   i_clk  - clock, rising edge
//   i_en   - access enable; read register holds its value when low
//   i_we   - write strobe (qualified by i_en)
//   i_addr - word address
//   i_din  - write data
//   o_dout - registered read data
module bus_resp_ram #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout
);

  logic [7:0] r_mem [2**AW];
  logic [7:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_din;
        r_dout        <= i_din;
      end else begin
        r_dout <= r_mem[i_addr];
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/bus_resp.sv
// bus_resp: memory side of the 65C02 AB/WE/DO/DB bus. Addresses below
// 2^RAM_AW hit the on-chip RAM with zero wait states; everything else is
// forwarded to an external 8-bit bus that takes EXT_WAIT cycles.
//
// Handshake: AB/WE/DO are accepted at every rising edge where RDY=1. While
// RDY=0 the core holds AB/WE/DO and ignores DB; DB is valid whenever RDY=1.
//
// Ports:
//   clk, reset         - clock (rising edge), asynchronous active-low reset
//   AB, WE, DO         - core address, write strobe, write data
//   DB, RDY            - read data to the core, ready/stall
//   ext_addr, ext_dout - latched external address / write data
//   ext_din            - external read data, sampled on the last wait cycle
//   ext_cs, ext_we     - external access active / external write
//   o_dbg_state        - current FSM state, for observation only
module bus_resp
  import bus_resp_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int EXT_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        RDY,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic        ext_cs,
  output logic        ext_we,
  output state_t      o_dbg_state
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXT_WAIT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_ext_addr;
  logic [7:0]       r_ext_dout;
  logic             r_ext_we;
  logic [7:0]       r_hold;
  db_sel_t          r_db_sel;

  logic             w_rdy;
  logic             w_cs;
  logic             w_int;
  logic             w_ram_en;
  logic [7:0]       w_ram_dout;
  logic [7:0]       w_db;

  assign w_int    = is_internal(AB, RAM_AW);
  assign w_ram_en = w_rdy & w_int;

  bus_resp_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .i_clk  (clk),
    .i_en   (w_ram_en),
    .i_we   (WE),
    .i_addr (AB[RAM_AW-1:0]),
    .i_din  (DO),
    .o_dout (w_ram_dout)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and control outputs
  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b1;
    w_cs   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new access exactly like IDLE.
        w_next = w_int ? ST_IDLE : ST_EXT;
      end
      ST_EXT: begin
        w_rdy = 1'b0;
        w_cs  = 1'b1;
        if (r_cnt == '0) begin
          w_next = ST_DONE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: counter, external latches, DB hold register and select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_ext_addr <= 16'h0000;
      r_ext_dout <= 8'h00;
      r_ext_we   <= 1'b0;
      r_hold     <= 8'h00;
      r_db_sel   <= DB_SEL_HOLD;
    end else if (w_rdy) begin
      // Snapshot the current DB so that writes and external accesses keep
      // showing it even after the RAM read register has moved on.
      r_hold   <= w_db;
      r_db_sel <= (w_int && !WE) ? DB_SEL_RAM : DB_SEL_HOLD;
      if (!w_int) begin
        r_ext_addr <= AB;
        r_ext_dout <= DO;
        r_ext_we   <= WE;
        r_cnt      <= CNT_INIT;
      end
    end else begin
      if (r_cnt == '0) begin
        if (!r_ext_we) begin
          r_hold <= ext_din;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_db        = (r_db_sel == DB_SEL_RAM) ? w_ram_dout : r_hold;
  assign DB          = w_db;
  assign RDY         = w_rdy;
  // Derived from the state register so reset drops them without a clock.
  assign ext_cs      = w_cs;
  assign ext_we      = w_cs & r_ext_we;
  assign ext_addr    = r_ext_addr;
  assign ext_dout    = r_ext_dout;
  assign o_dbg_state = r_state;

endmodule

// File: doc/bus_resp.md
# bus_resp

Bus responder for the 65C02 core: the memory side of the core's AB/WE/DO/DB bus. It sits between the core and all storage. It serves an on-chip RAM window with zero wait states, and forwards every other address to an external 8-bit bus with a programmable number of wait states. While an external access is in progress it stalls the core with RDY.

## Interface
- RAM_AW, 12: internal RAM address width; window is 0x0000 .. 2^RAM_AW-1 (8..15 legal)
- EXT_WAIT, 2: external access length in cycles (1..15)

- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- AB  in  16  core address for the current cycle
- WE  in  1  core write strobe for the current cycle
- DO  in  8  core write data, valid with WE
- DB  out  8  read data returned to the core
- RDY  out  1  1 = DB valid / access accepted; 0 = core must hold AB/WE/DO and ignore DB
- ext_addr  out  16  latched external address
- ext_dout  out  8  latched external write data
- ext_din  in  8  external read data, sampled on the last wait cycle
- ext_cs  out  1  external access active
- ext_we  out  1  external write (qualifies ext_cs)

## Operation
- Acceptance: AB/WE/DO are sampled at every rising edge where RDY=1. The accepted access is decoded as internal (AB < 2^RAM_AW) or external.
- States: IDLE, EXT, DONE.
- IDLE:
  - RDY=1.
  - An internal access is accepted. A write stores DO at the edge. A read puts RAM[AB] on DB in the next cycle. State stays IDLE.
  - An external access is accepted. ext_addr and ext_dout are latched and the wait counter is loaded with EXT_WAIT-1. The block moves to EXT.
- EXT:
  - RDY=0, ext_cs=1, ext_we = latched WE. The counter decrements each cycle.
  - When the counter is 0: for a read, ext_din is captured into the DB hold register, then DONE.
- DONE:
  - RDY=1 and DB = captured data; for writes, DB repeats the previous DB value.
  - ext_cs=0, ext_we=0.
  - The access on AB in this cycle is accepted exactly as in IDLE. Next state is EXT for an external access, otherwise IDLE.
- DB source: a registered select chooses RAM output (last accepted access was an internal read) or hold register (all other cases). Write cycles and cycles with no prior access hold the last DB value.
- Internal read-after-write to the same address in consecutive cycles returns the new data; the RAM is write-first.
- Address wrap: none. Bits above RAM_AW are decode only.

## Timing
- Internal read: address accepted at cycle N, DB valid in N+1 with RDY=1. Zero wait states, back-to-back accesses allowed.
- External access accepted at N:
  - ext_cs=1 and RDY=0 during N+1 .. N+EXT_WAIT.
  - ext_din is sampled at the edge ending N+EXT_WAIT.
  - DB valid with RDY=1 in N+EXT_WAIT+1.
- ext_addr, ext_dout and ext_we are stable for the whole time ext_cs=1. They keep their values after completion.
- Reset values (asynchronous, while reset=0):
  - state IDLE, RDY=1, DB=8'h00, DB select = hold register.
  - ext_cs=0, ext_we=0, ext_addr=16'h0000, ext_dout=8'h00, counter 0.
- Reset during EXT aborts the access; ext_cs and ext_we drop immediately, without waiting for a clock. RAM contents are not reset.
- No access is accepted on the first edge after reset release unless RDY=1, and RDY=1 is always true after reset.

## Structure
- Package bus_resp_pkg holds:
  - state enum (IDLE, EXT, DONE)
  - counter width constant (4)
  - DB-select encoding
  - the internal-window decode function
- Sub-module bus_resp_ram: single-port synchronous RAM, 2^RAM_AW x 8, write-first, registered read, no reset.
- Top level contains the FSM, counter, latches and DB mux.

## Test plan
- Reset release, no accesses: RDY=1, DB=8'h00, ext_cs=0.
- Internal write 0x0200<=0x5A, then read 0x0200 in the next cycle: DB=0x5A one cycle after the read is accepted, RDY never low.
- External read at 0x8000 with EXT_WAIT=2 and ext_din=0xC3: ext_cs=1 and RDY=0 for exactly 2 cycles, ext_addr=0x8000, then DB=0xC3 with RDY=1.
- External write 0xFFFA<=0x12 followed in the DONE cycle by an internal read of 0x0010: ext_we=1 for EXT_WAIT cycles, ext_dout=0x12, then RAM[0x0010] on DB the next cycle, no extra stall.
- Back-to-back external reads 0x9000 and 0x9001 (EXT_WAIT=3): second ext_cs starts in the cycle after the DONE cycle, total 8 cycles.
- reset asserted mid-EXT: ext_cs/ext_we fall without a clock edge, RDY=1, DB=0x00. The next external access after release completes normally.
